linea_retardo_taps: RTL

- Parametrised tapped delay line for the equalizer's FIR filter banks.
- Extends the plain sample register into a chain of DEPTH registers that advance only on the sample strobe, with:
  - synchronous clear;
  - a fill counter and full flag;
  - an optional registered symmetric-pair adder for linear-phase filters.
- Sits between the ADC sample path and each filter's multiply-accumulate stage.

---
 rtl/eq_pkg.sv | 33 +++
 rtl/etapa_retardo.sv | 43 ++++
 rtl/linea_retardo_taps.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eq_pkg
//  Description : Shared definitions for the equalizer FIR tapped delay lines:
//                default sample width, maximum line depth, and the helper
//                functions for the symmetric-pair slot count and the
//                fill-counter width.
//  Revision    : 1.0  - initial release
// ============================================================================
package eq_pkg;

    localparam int DEF_BITS  = 12;
    localparam int MAX_DEPTH = 64;

    // Number of symmetric-pair slots; for odd depth, the centre tap gets its own slot
    function automatic int ns_f(input int depth);
        return (depth + 1) / 2;
    endfunction

    // Ceiling log2; used as clog2(DEPTH+1) so the counter can hold DEPTH itself
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : eq_pkg
`default_nettype wire

// File: rtl/etapa_retardo.sv
`default_nettype none
// ============================================================================
//  Module      : etapa_retardo
//  Description : One stage of the tapped delay line: a BITS-wide register
//                with asynchronous active-high reset, synchronous clear and
//                load enable. Clear has priority over enable.
//  Ports       : clk    - system clock
//                reset  - asynchronous active-high reset
//                clr_i  - synchronous clear
//                en_i   - load enable (sample strobe)
//                d_i    - data in
//                q_o    - registered data out
//  Revision    : 1.0  - initial release
// ============================================================================
module etapa_retardo
    import eq_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [BITS-1:0] d_i,
    output logic [BITS-1:0] q_o
);

    logic [BITS-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : etapa_retardo
`default_nettype wire

// File: rtl/linea_retardo_taps.sv
`default_nettype none
// ============================================================================
//  Module      : linea_retardo_taps
//  Description : Parametrised tapped delay line for the equalizer FIR banks.
//                DEPTH registers shift on the sample strobe; a saturating
//                fill counter and full flag track how many samples are
//                valid. Optional registered symmetric-pair adder for
//                linear-phase filters.
//  Config macro: LINEA_RETARDO_SYMSUM_EN - when defined, adds the sums and
//                sum_vld ports plus the pair adders and their registers.
//  Ports       : clk     - system clock
//                reset   - asynchronous active-high reset
//                en      - sample strobe (shift when high)
//                clr     - synchronous clear, priority over en
//                dd      - new sample, signed
//                taps    - all taps flattened, tap k at [k*BITS +: BITS],
//                          tap 0 newest
//                fill    - valid sample count, saturates at DEPTH
//                full    - fill == DEPTH
//                sums    - symmetric-pair sums, BITS+1 per slot (macro only)
//                sum_vld - sums-valid flag (macro only)
//  Revision    : 1.0  - initial release
// ============================================================================
module linea_retardo_taps
    import eq_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               clr,
    input  logic [BITS-1:0]                    dd,
    output logic [DEPTH*BITS-1:0]              taps,
    output logic [clog2_f(DEPTH+1)-1:0]        fill,
    output logic                               full
`ifdef LINEA_RETARDO_SYMSUM_EN
    ,
    output logic [ns_f(DEPTH)*(BITS+1)-1:0]    sums,
    output logic                               sum_vld
`endif
);

    localparam int FW = clog2_f(DEPTH + 1);
    localparam int NS = ns_f(DEPTH);

    // ------------------------------------------------------------------
    // Delay chain
    // ------------------------------------------------------------------
    logic [BITS-1:0] tap_w [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tap
        logic [BITS-1:0] d_w;

        if (k == 0) begin : g_head
            assign d_w = dd;
        end else begin : g_body
            assign d_w = tap_w[k-1];
        end

        etapa_retardo #(
            .BITS (BITS)
        ) u_etapa (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr),
            .en_i  (en),
            .d_i   (d_w),
            .q_o   (tap_w[k])
        );

        assign taps[k*BITS +: BITS] = tap_w[k];
    end

    // ------------------------------------------------------------------
    // Fill counter
    // ------------------------------------------------------------------
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;

    always_comb begin
        fill_d = fill_q;
        if (clr) begin
            fill_d = '0;
        end else if (en && (fill_q != FW'(DEPTH))) begin
            fill_d = fill_q + FW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;
    assign full = (fill_q == FW'(DEPTH));

`ifdef LINEA_RETARDO_SYMSUM_EN
    // ------------------------------------------------------------------
    // Symmetric-pair adder. The sum of two sign-extended BITS-wide values
    // always fits in BITS+1 bits, so no saturation is needed.
    // ------------------------------------------------------------------
    logic [BITS:0] pair_w [NS];

    for (genvar i = 0; i < NS; i++) begin : g_pair
        if (i < DEPTH / 2) begin : g_sum
            assign pair_w[i] = {tap_w[i][BITS-1], tap_w[i]}
                             + {tap_w[DEPTH-1-i][BITS-1], tap_w[DEPTH-1-i]};
        end else begin : g_center
            // Only reached for odd depth: i == DEPTH/2 is the centre tap
            assign pair_w[i] = {tap_w[i][BITS-1], tap_w[i]};
        end
    end

    logic [NS*(BITS+1)-1:0] sums_d;

    always_comb begin
        sums_d = '0;
        for (int i = 0; i < NS; i++) begin
            sums_d[i*(BITS+1) +: (BITS+1)] = pair_w[i];
        end
    end

    logic [NS*(BITS+1)-1:0] sums_q;
    logic                   shift_q;   // a real shift happened on the previous edge
    logic                   sum_vld_q;

    // Sums sample the taps one edge after they shift, so a valid pulse
    // follows each accepted strobe. A clear kills both the pulse on its own
    // edge and, through shift_q, the pulse on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sums_q    <= '0;
            shift_q   <= 1'b0;
            sum_vld_q <= 1'b0;
        end else if (clr) begin
            sums_q    <= '0;
            shift_q   <= 1'b0;
            sum_vld_q <= 1'b0;
        end else begin
            sums_q    <= sums_d;
            shift_q   <= en;
            sum_vld_q <= shift_q;
        end
    end

    assign sums    = sums_q;
    assign sum_vld = sum_vld_q;
`endif

endmodule : linea_retardo_taps
`default_nettype wire
